// File: rtl/core_dmem_arbiter.sv
// Two-master arbiter for the core data memory port (s0 = LSU, s1 = debug / page walker).
// Build option: define CORE_DMEM_ARB_RR_EN for round-robin; otherwise s0 has fixed priority.

module core_dmem_arbiter_port #(
   parameter bit PORT_ID = 1'b0
) (
   input  logic g_resetn,
   input  logic sel,
   input  logic m_req,
   input  logic m_gnt,
   input  logic rsp_pend,
   input  logic rsp_sel,
   input  logic m_err,
   output logic gnt,
   output logic rsp,
   output logic err
);
   assign gnt = m_gnt && m_req && (sel == PORT_ID);
   // Gated by reset so a response registered just before reset never escapes.
   assign rsp = g_resetn && rsp_pend && (rsp_sel == PORT_ID);
   assign err = rsp && m_err;
endmodule

module core_dmem_arbiter #(
   parameter int ADDR_W = 64,
   parameter int DATA_W = 64,
   parameter int STRB_W = 8
) (
   input  logic              g_clk,
   input  logic              g_resetn,
   input  logic              s0_req,
   input  logic [ADDR_W-1:0] s0_addr,
   input  logic              s0_wen,
   input  logic [STRB_W-1:0] s0_strb,
   input  logic [DATA_W-1:0] s0_wdata,
   output logic              s0_gnt,
   output logic              s0_rsp,
   output logic              s0_err,
   input  logic              s1_req,
   input  logic [ADDR_W-1:0] s1_addr,
   input  logic              s1_wen,
   input  logic [STRB_W-1:0] s1_strb,
   input  logic [DATA_W-1:0] s1_wdata,
   output logic              s1_gnt,
   output logic              s1_rsp,
   output logic              s1_err,
   output logic [DATA_W-1:0] s_rdata,
   output logic              m_req,
   output logic [ADDR_W-1:0] m_addr,
   output logic              m_wen,
   output logic [STRB_W-1:0] m_strb,
   output logic [DATA_W-1:0] m_wdata,
   input  logic              m_gnt,
   input  logic              m_err,
   input  logic [DATA_W-1:0] m_rdata
);
   typedef struct packed {
      logic              req;
      logic [ADDR_W-1:0] addr;
      logic              wen;
      logic [STRB_W-1:0] strb;
      logic [DATA_W-1:0] wdata;
   } dmem_req_t;

   dmem_req_t [1:0] prt;
   dmem_req_t       cur;

   logic       lock, lock_sel;
   logic       rsp_pend, rsp_sel;
   logic       sel;
   logic       grant;
   logic [1:0] gnt, rsp, err;

   assign prt[0] = {s0_req, s0_addr, s0_wen, s0_strb, s0_wdata};
   assign prt[1] = {s1_req, s1_addr, s1_wen, s1_strb, s1_wdata};

`ifdef CORE_DMEM_ARB_RR_EN
   logic rr_last;
`endif

   always_comb begin
      sel = 1'b0;
      if (lock)
         sel = lock_sel;
      else if (s0_req && s1_req)
`ifdef CORE_DMEM_ARB_RR_EN
         sel = !rr_last;
`else
         sel = 1'b0;
`endif
      else
         sel = s1_req;
   end

   assign cur     = prt[sel];
   assign m_req   = g_resetn && cur.req;
   assign m_addr  = cur.addr;
   assign m_wen   = cur.wen;
   assign m_strb  = cur.strb;
   assign m_wdata = cur.wdata;
   assign grant   = m_req && m_gnt;
   assign s_rdata = m_rdata;

   // Lock follows an outstanding ungranted request; a grant or a dropped request clears it.
   always_ff @(posedge g_clk) begin
      if (!g_resetn) begin
         lock     <= 1'b0;
         lock_sel <= 1'b0;
         rsp_pend <= 1'b0;
         rsp_sel  <= 1'b0;
      end else begin
         lock     <= m_req && !m_gnt;
         if (m_req && !m_gnt)
            lock_sel <= sel;
         rsp_pend <= grant;
         if (grant)
            rsp_sel <= sel;
      end
   end

`ifdef CORE_DMEM_ARB_RR_EN
   always_ff @(posedge g_clk) begin
      if (!g_resetn)
         rr_last <= 1'b0;
      else if (grant)
         rr_last <= sel;
   end
`endif

   for (genvar i = 0; i < 2; i++) begin : g_port
      core_dmem_arbiter_port #(
         .PORT_ID (i == 1)
      ) u_port (
         .g_resetn (g_resetn),
         .sel      (sel),
         .m_req    (m_req),
         .m_gnt    (m_gnt),
         .rsp_pend (rsp_pend),
         .rsp_sel  (rsp_sel),
         .m_err    (m_err),
         .gnt      (gnt[i]),
         .rsp      (rsp[i]),
         .err      (err[i])
      );
   end

   assign s0_gnt = gnt[0];
   assign s1_gnt = gnt[1];
   assign s0_rsp = rsp[0];
   assign s1_rsp = rsp[1];
   assign s0_err = err[0];
   assign s1_err = err[1];
endmodule
